serial_subtractor8: RTL

Bit-serial 8-bit two's-complement subtractor with a borrow-in. It computes `diff = a - b - borrowInput` one bit per clock, LSB first, using a single full-adder cell and shift registers. It is the subtraction counterpart of the 8-bit ripple-carry adder in the datapath library. It trades eight cycles of latency for one full-adder cell, and uses a start/done handshake so a sequencing controller can drive it.

---
 rtl/serial_subtractor8.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor8.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrowInput.
// One full-adder cell adds a + ~b + ~borrowInput, LSB first.
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowInput,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOutput,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic sum_bit;
    logic carry_bit;
    logic last_bit;

    always_comb begin
        sum_bit   = a_q[0] ^ nb_q[0] ^ c_q;
        carry_bit = (a_q[0] & nb_q[0]) | (a_q[0] & c_q) | (nb_q[0] & c_q);
        last_bit  = (cnt_q == LAST);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    nb_d    = ~b;
                    c_d     = ~borrowInput;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                res_d = {sum_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                nb_d  = nb_q >> 1;
                c_d   = carry_bit;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    // c_q is the carry into the MSB at this point
                    diff_d  = {sum_bit, res_q[WIDTH-1:1]};
                    bout_d  = ~carry_bit;
                    ovf_d   = c_q ^ carry_bit;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign diff         = diff_q;
    assign borrowOutput = bout_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q == SHIFT);
    assign done         = (state_q == DONE);

endmodule
